// File: rtl/router_sync_param_if.sv
// ---------------------------------------------------------------------------
// router_sync_if : bundles the signals between the router FSM, the output
// FIFOs and the router synchroniser.
//   data_in       : destination address field of the header byte
//   detect_add    : header present, latch data_in
//   write_enb_reg : FSM request to write the current byte
//   full / empty  : per-FIFO status flags
//   read_enb      : per-port read strobes from the destinations
//   write_enb     : one-hot FIFO write enables
//   fifo_full     : full flag of the addressed FIFO
//   vld_out       : per-port data valid
//   soft_reset    : per-FIFO one-cycle soft reset
//   addr_err      : last latched address is out of range
// Optional (macro ROUTER_SYNC_TO_STATUS_EN): to_clr in, to_sticky out.
// slave modport is the synchroniser; master is the surrounding logic.
// ---------------------------------------------------------------------------
interface router_sync_if #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 2
);
    logic [ADDR_W-1:0]    data_in;
    logic                 detect_add;
    logic                 write_enb_reg;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] read_enb;
    logic [NUM_PORTS-1:0] write_enb;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] vld_out;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 addr_err;
`ifdef ROUTER_SYNC_TO_STATUS_EN
    logic                 to_clr;
    logic [NUM_PORTS-1:0] to_sticky;

    modport slave (
        input  data_in, detect_add, write_enb_reg, full, empty, read_enb, to_clr,
        output write_enb, fifo_full, vld_out, soft_reset, addr_err, to_sticky
    );
    modport master (
        output data_in, detect_add, write_enb_reg, full, empty, read_enb, to_clr,
        input  write_enb, fifo_full, vld_out, soft_reset, addr_err, to_sticky
    );
`else
    modport slave (
        input  data_in, detect_add, write_enb_reg, full, empty, read_enb,
        output write_enb, fifo_full, vld_out, soft_reset, addr_err
    );
    modport master (
        output data_in, detect_add, write_enb_reg, full, empty, read_enb,
        input  write_enb, fifo_full, vld_out, soft_reset, addr_err
    );
`endif
endinterface

// File: rtl/router_sync_param.sv
// ---------------------------------------------------------------------------
// router_sync_param : synchroniser between the router FSM, the register block
// and NUM_PORTS output FIFOs. Latches the destination address, decodes the
// FIFO write enables, muxes back the addressed full flag, drives per-port
// valids and soft-resets any FIFO left unread for TIMEOUT cycles.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : router_sync_if.slave (see interface header for signal list)
// Optional feature macro ROUTER_SYNC_TO_STATUS_EN adds a sticky per-port
// timeout status (bus.to_sticky) with a clear strobe (bus.to_clr).
// ---------------------------------------------------------------------------
module router_sync_param #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned TIMEOUT   = 30
) (
    input  logic          clock,
    input  logic          reset,
    router_sync_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    logic [ADDR_W-1:0]    r_addr;
    logic                 r_addr_err;
    logic                 w_addr_valid;
    logic [NUM_PORTS-1:0] w_vld;
    logic [NUM_PORTS-1:0] w_write_enb;
    logic                 w_fifo_full;

    // Destination address latch and out-of-range flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_addr_err <= 1'b0;
        end else if (bus.detect_add) begin
            r_addr     <= bus.data_in;
            r_addr_err <= (32'(bus.data_in) >= NUM_PORTS);
        end
    end

    assign w_addr_valid = (32'(r_addr) < NUM_PORTS);
    assign w_vld        = ~bus.empty;

    // Write-enable decode and full-flag mux; both held low while in reset
    always_comb begin
        w_write_enb = '0;
        w_fifo_full = 1'b0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (w_addr_valid && (r_addr == ADDR_W'(i))) begin
                w_write_enb[i] = bus.write_enb_reg & ~reset;
                w_fifo_full    = bus.full[i] & ~reset;
            end
        end
    end

    assign bus.write_enb = w_write_enb;
    assign bus.fifo_full = w_fifo_full;
    assign bus.vld_out   = w_vld;
    assign bus.addr_err  = r_addr_err;

    // Per-port read-timeout counter with one-cycle soft-reset pulse
    for (genvar g = 0; g < int'(NUM_PORTS); g++) begin : g_port
        logic [CNT_W-1:0] r_cnt;
        logic             r_soft_reset;
        logic             w_run;
        logic             w_term;

        assign w_run  = w_vld[g] & ~bus.read_enb[g];
        assign w_term = w_run & (r_cnt == CNT_W'(TIMEOUT - 1));

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_cnt        <= '0;
                r_soft_reset <= 1'b0;
            end else if (w_term) begin
                r_cnt        <= '0;
                r_soft_reset <= 1'b1;
            end else if (w_run) begin
                r_cnt        <= r_cnt + CNT_W'(1);
                r_soft_reset <= 1'b0;
            end else begin
                r_cnt        <= '0;
                r_soft_reset <= 1'b0;
            end
        end

        assign bus.soft_reset[g] = r_soft_reset;

`ifdef ROUTER_SYNC_TO_STATUS_EN
        logic r_sticky;

        // Set on the pulse-raising edge; set beats a simultaneous clear
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_sticky <= 1'b0;
            end else if (w_term) begin
                r_sticky <= 1'b1;
            end else if (bus.to_clr) begin
                r_sticky <= 1'b0;
            end
        end

        assign bus.to_sticky[g] = r_sticky;
`endif
    end
endmodule

// File: tb/tb_router_sync_param.sv
// ---------------------------------------------------------------------------
// tb_router_sync_param : directed self-checking bench for router_sync_param
// (NUM_PORTS=3, ADDR_W=2, TIMEOUT=30).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_router_sync_param;
    localparam int unsigned NP = 3;
    localparam int unsigned AW = 2;
    localparam int unsigned TO = 30;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;

    router_sync_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

    router_sync_param #(.NUM_PORTS(NP), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.data_in       = '0;
        bus.detect_add    = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.full          = '0;
        bus.empty         = '1;
        bus.read_enb      = '0;
`ifdef ROUTER_SYNC_TO_STATUS_EN
        bus.to_clr        = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        // inline-style single comparison, used by every scenario task
        n_checks++;
        if (act !== exp_v)
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp_v);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.write_enb_reg = 1'b1;
        bus.full          = 3'b111;
        bus.empty         = 3'b010;
        reset = 1'b1;
        #3;
        chk("reset_write_enb_forced", 32'(bus.write_enb), 32'h0);
        chk("reset_fifo_full_forced", 32'(bus.fifo_full), 32'h0);
        chk("reset_addr_err", 32'(bus.addr_err), 32'h0);
        chk("reset_soft_reset", 32'(bus.soft_reset), 32'h0);
        chk("reset_vld_out", 32'(bus.vld_out), 32'h5);
        tick();
        reset = 1'b0;
        #1;
        // address resets to 0, which is valid
        chk("post_reset_write_enb", 32'(bus.write_enb), 32'h1);
        chk("post_reset_fifo_full", 32'(bus.fifo_full), 32'h1);
        idle_inputs();
    endtask

    task automatic test_write_path();
        do_reset();
        bus.detect_add = 1'b1;
        bus.data_in    = 2'd2;
        tick();
        bus.detect_add    = 1'b0;
        bus.write_enb_reg = 1'b1;
        bus.full          = 3'b100;
        #1;
        chk("valid_write_enb", 32'(bus.write_enb), 32'h4);
        chk("valid_fifo_full", 32'(bus.fifo_full), 32'h1);
        chk("valid_addr_err", 32'(bus.addr_err), 32'h0);
        bus.full = 3'b011;
        #1;
        chk("valid_fifo_full_other", 32'(bus.fifo_full), 32'h0);
        bus.write_enb_reg = 1'b0;
        #1;
        chk("valid_write_enb_idle", 32'(bus.write_enb), 32'h0);
        bus.empty = 3'b010;
        #1;
        chk("vld_out_pattern", 32'(bus.vld_out), 32'h5);
        idle_inputs();
    endtask

    task automatic test_invalid_addr();
        do_reset();
        bus.detect_add = 1'b1;
        bus.data_in    = 2'd3;
        tick();
        bus.detect_add    = 1'b0;
        bus.write_enb_reg = 1'b1;
        bus.full          = 3'b111;
        #1;
        chk("inv_write_enb", 32'(bus.write_enb), 32'h0);
        chk("inv_fifo_full", 32'(bus.fifo_full), 32'h0);
        chk("inv_addr_err", 32'(bus.addr_err), 32'h1);
        bus.detect_add = 1'b1;
        bus.data_in    = 2'd0;
        tick();
        bus.detect_add = 1'b0;
        bus.data_in    = 2'd1;
        #1;
        chk("reval_addr_err", 32'(bus.addr_err), 32'h0);
        chk("reval_write_enb", 32'(bus.write_enb), 32'h1);
        chk("reval_fifo_full", 32'(bus.fifo_full), 32'h1);
        tick();
        // detect_add low: address must hold at 0
        chk("hold_write_enb", 32'(bus.write_enb), 32'h1);
        idle_inputs();
    endtask

    task automatic test_timeout();
        int first_edge;
        int second_edge;
        int pulses;
        int others;
        do_reset();
        first_edge = 0; second_edge = 0; pulses = 0; others = 0;
        bus.empty = 3'b101;
        for (int e = 1; e <= 65; e++) begin
            tick();
            if (bus.soft_reset[1]) begin
                pulses++;
                if (first_edge == 0) first_edge = e;
                else if (second_edge == 0) second_edge = e;
            end
            if (bus.soft_reset[0] || bus.soft_reset[2]) others++;
        end
        chk("timeout_first_edge", 32'(first_edge), 32'd30);
        chk("timeout_second_edge", 32'(second_edge), 32'd60);
        chk("timeout_pulse_count", 32'(pulses), 32'd2);
        chk("timeout_other_ports", 32'(others), 32'd0);
        idle_inputs();
    endtask

    task automatic test_read_rescue();
        int first_edge;
        do_reset();
        first_edge = 0;
        bus.empty = 3'b110;
        for (int e = 1; e <= 62; e++) begin
            // read arrives on the terminal-count edge
            bus.read_enb[0] = (e == 30);
            tick();
            if (bus.soft_reset[0] && first_edge == 0) first_edge = e;
        end
        chk("rescue_first_pulse_edge", 32'(first_edge), 32'd60);
        idle_inputs();
    endtask

    task automatic test_async_reset();
        int first_edge;
        do_reset();
        first_edge = 0;
        bus.detect_add = 1'b1;
        bus.data_in    = 2'd3;
        tick();
        bus.detect_add = 1'b0;
        bus.empty      = 3'b011;
        for (int e = 1; e <= 14; e++) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_addr_err_clear", 32'(bus.addr_err), 32'h0);
        chk("async_soft_reset_clear", 32'(bus.soft_reset), 32'h0);
        chk("async_vld_out", 32'(bus.vld_out), 32'h4);
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 35; e++) begin
            tick();
            if (bus.soft_reset[2] && first_edge == 0) first_edge = e;
        end
        chk("async_restart_pulse_edge", 32'(first_edge), 32'd30);
        idle_inputs();
    endtask

`ifdef ROUTER_SYNC_TO_STATUS_EN
    task automatic test_sticky();
        do_reset();
        chk("sticky_reset", 32'(bus.to_sticky), 32'h0);
        bus.empty = 3'b011;
        for (int e = 1; e <= 30; e++) tick();
        chk("sticky_set", 32'(bus.to_sticky), 32'h4);
        for (int e = 31; e <= 59; e++) tick();
        chk("sticky_hold", 32'(bus.to_sticky), 32'h4);
        bus.to_clr = 1'b1;
        tick();
        chk("sticky_pulse_with_clr", 32'(bus.soft_reset), 32'h4);
        chk("sticky_set_wins", 32'(bus.to_sticky), 32'h4);
        bus.empty = 3'b111;
        tick();
        chk("sticky_cleared", 32'(bus.to_sticky), 32'h0);
        idle_inputs();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        idle_inputs();
        test_reset();
        test_write_path();
        test_invalid_addr();
        test_timeout();
        test_read_rescue();
        test_async_reset();
`ifdef ROUTER_SYNC_TO_STATUS_EN
        test_sticky();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/router_sync_param.md
Name: router_sync_param

Overview:
Parametrised synchroniser between the router FSM, the register block and NUM_PORTS output FIFOs.
- Latches the destination address on header detect.
- Decodes per-FIFO write enables and muxes the selected FIFO's full flag back to the FSM.
- Drives per-port valid outputs.
- Runs a per-port read-timeout counter that pulses a soft reset into any FIFO left unread for TIMEOUT cycles.
- Adds invalid-address detection, one-cycle soft-reset pulses with counter restart, and a compile-time sticky timeout status.

Parameters:
- NUM_PORTS, 3, number of output FIFOs/ports (2..16).
- ADDR_W, 2, width of the address field in data_in; must satisfy 2**ADDR_W >= NUM_PORTS.
- TIMEOUT, 30, consecutive unread-valid cycles before soft reset (>= 2).
- CNT_W (localparam), $clog2(TIMEOUT), width of each timeout counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  ADDR_W  destination address field of the header byte.
- detect_add  in  1  header present; latch data_in this edge.
- write_enb_reg  in  1  FSM request to write the current byte.
- full  in  NUM_PORTS  per-FIFO full flags.
- empty  in  NUM_PORTS  per-FIFO empty flags.
- read_enb  in  NUM_PORTS  per-port read strobes from the destinations.
- write_enb  out  NUM_PORTS  one-hot FIFO write enables.
- fifo_full  out  1  full flag of the addressed FIFO.
- vld_out  out  NUM_PORTS  per-port data valid.
- soft_reset  out  NUM_PORTS  per-FIFO soft reset, one-cycle pulse.
- addr_err  out  1  last latched address is out of range.

Behaviour:
- Reset (async, active-high): addr_q=0, addr_err=0, all counters=0, soft_reset=0. While reset is high, write_enb=0 and fifo_full=0 (forced combinationally). vld_out always equals ~empty, including during reset.
- Address latch: on each clock edge with detect_add=1, addr_q<=data_in and addr_err<=(data_in>=NUM_PORTS). No change when detect_add=0. A re-latch mid-packet is allowed and takes effect from the next cycle.
- addr_valid = (addr_q < NUM_PORTS).
- write_enb[i] (combinational, zero latency) = write_enb_reg & addr_valid & (addr_q==i). At most one bit is set. All zero when the address is invalid.
- fifo_full (combinational) = addr_valid ? full[addr_q] : 0.
- vld_out[i] = ~empty[i], combinational.
- Timeout counter, per port i, evaluated each edge:
  - vld_out[i]=1 and read_enb[i]=0:
    - cnt==TIMEOUT-1: soft_reset[i]<=1, cnt<=0.
    - otherwise: cnt<=cnt+1, soft_reset[i]<=0.
  - vld_out[i]=0 or read_enb[i]=1: cnt<=0, soft_reset[i]<=0.
- Timeout latency: empty falls before edge 1 and no reads follow. soft_reset goes high for exactly one cycle after edge TIMEOUT. If the FIFO stays non-empty and unread, the next pulse comes TIMEOUT cycles later.
- A read on the same edge as the terminal count wins: counter clears and no pulse is issued.
- Ports are fully independent; simultaneous timeouts on several ports pulse together.
- Reset asserted mid-count clears counters and pulses immediately (async). Counting restarts from 0 after release.

Optional Feature:
Macro ROUTER_SYNC_TO_STATUS_EN.
- Defined: adds input to_clr (1) and output to_sticky (NUM_PORTS).
  - to_sticky[i] sets on the edge that raises soft_reset[i] and holds until to_clr=1 or reset.
  - to_clr clears all bits on the next edge.
  - Set wins over clear on the same edge.
  - Reset value 0.
- Undefined: neither port exists. All other behaviour is identical.

Test Plan:
- Valid write path: reset, detect_add=1 with data_in=2, then write_enb_reg=1 and full=3'b100 -> write_enb=3'b100, fifo_full=1; write_enb_reg=0 -> write_enb=0.
- Invalid address: detect_add with data_in=3 (NUM_PORTS=3), write_enb_reg=1 -> write_enb=0, fifo_full=0, addr_err=1. Next detect_add with data_in=0 -> addr_err=0, write_enb=3'b001.
- Timeout: empty[1]=0, read_enb[1]=0 held -> soft_reset[1] high for exactly one cycle after the 30th edge, low again next cycle, next pulse 30 cycles later.
- Read rescue: empty[0]=0; read_enb[0]=1 at cycle 29 -> no soft_reset[0] pulse; counter restarts and a pulse occurs only after 30 further unread cycles.
- Async reset mid-count: reset asserted at count 15 (between edges) -> counters and outputs clear immediately; after release, 30 fresh unread cycles are needed before soft_reset.
- With ROUTER_SYNC_TO_STATUS_EN: timeout on port 2 -> to_sticky=3'b100 held. to_clr=1 on the same edge as a new port-2 pulse -> to_sticky[2] stays 1. to_clr alone -> 0.
